// File: rtl/sprite_motion_pkg.sv
// sprite_motion_pkg: shared coordinate width, screen geometry, default bounds and motion FSM states
package sprite_motion_pkg;
   localparam int COORD_W   = 12;
   localparam int SCREEN_W  = 1024;
   localparam int SCREEN_H  = 768;
   localparam int HALF_SIZE = 32;
   localparam int DEF_X_MIN = HALF_SIZE;
   localparam int DEF_X_MAX = SCREEN_W - HALF_SIZE - 1;
   localparam int DEF_Y_MIN = HALF_SIZE;
   localparam int DEF_Y_MAX = SCREEN_H - HALF_SIZE - 1;

   typedef logic signed [COORD_W-1:0] coord_t;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT_FRAME, ST_STEP} state_t;

   function automatic coord_t clamp(input coord_t v, input int lo, input int hi);
      return (v < lo) ? coord_t'(lo) : (v > hi) ? coord_t'(hi) : v;
   endfunction
endpackage

// File: rtl/sprite_motion_axis_stepper.sv
// axis_stepper: one-axis move of at most STEP pixels from pos toward target
//   pos, target : current and requested coordinate
//   next_pos    : position after one frame step
//   at_target   : next_pos equals target
module axis_stepper
   import sprite_motion_pkg::*;
#(
   parameter int STEP = 4
) (
   input  coord_t pos,
   input  coord_t target,
   output coord_t next_pos,
   output logic   at_target
);
   localparam logic signed [COORD_W:0] S_D = (COORD_W+1)'(STEP);
   localparam coord_t S_P = coord_t'(STEP);
   logic signed [COORD_W:0] w_d;
   // one extra bit so the difference of two in-range coordinates cannot wrap
   assign w_d = {target[COORD_W-1], target} - {pos[COORD_W-1], pos};
   assign next_pos = (w_d >= -S_D && w_d <= S_D) ? target : pos + (w_d[COORD_W] ? -S_P : S_P);
   assign at_target = next_pos == target;
endmodule

// File: rtl/sprite_motion.sv
// sprite_motion: moves the sprite centre toward an accepted target by at most STEP px per axis per frame
//   clk, reset           : pixel clock, synchronous active-high reset
//   vsync                : active-low vertical sync; its falling edge commits a step
//   target_valid/ready   : handshake for target_x/target_y (clamped into bounds on acceptance)
//   x, y                 : registered sprite centre
//   moving, arrived      : stored target differs from position / one-cycle arrival pulse
module sprite_motion
   import sprite_motion_pkg::*;
#(
   parameter int STEP   = 4,
   parameter int X_MIN  = DEF_X_MIN,
   parameter int X_MAX  = DEF_X_MAX,
   parameter int Y_MIN  = DEF_Y_MIN,
   parameter int Y_MAX  = DEF_Y_MAX,
   parameter int INIT_X = 512,
   parameter int INIT_Y = 384
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   vsync,
   input  logic   target_valid,
   input  coord_t target_x,
   input  coord_t target_y,
   output logic   target_ready,
   output coord_t x,
   output coord_t y,
   output logic   moving,
   output logic   arrived
);
   state_t r_state;
   logic   r_vsync, r_moving, r_arrived;
   coord_t r_x, r_y, r_tx, r_ty;
   coord_t w_nx, w_ny, w_tx, w_ty, w_x, w_y;
   logic   w_at_x, w_at_y, w_xfer, w_fe, w_step;

   axis_stepper #(.STEP(STEP)) u_x (.pos(r_x), .target(r_tx), .next_pos(w_nx), .at_target(w_at_x));
   axis_stepper #(.STEP(STEP)) u_y (.pos(r_y), .target(r_ty), .next_pos(w_ny), .at_target(w_at_y));

   assign target_ready = !reset && r_state != ST_STEP;
   assign w_xfer = target_valid && target_ready;
   assign w_fe   = r_vsync && !vsync;
   assign w_step = r_state == ST_STEP;
   assign w_tx   = w_xfer ? clamp(target_x, X_MIN, X_MAX) : r_tx;
   assign w_ty   = w_xfer ? clamp(target_y, Y_MIN, Y_MAX) : r_ty;
   assign w_x    = w_step ? w_nx : r_x;
   assign w_y    = w_step ? w_ny : r_y;
   assign x       = r_x;
   assign y       = r_y;
   assign moving  = r_moving;
   assign arrived = r_arrived;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_vsync   <= 1'b1;
         r_x       <= coord_t'(INIT_X);
         r_y       <= coord_t'(INIT_Y);
         r_tx      <= coord_t'(INIT_X);
         r_ty      <= coord_t'(INIT_Y);
         r_moving  <= 1'b0;
         r_arrived <= 1'b0;
      end else begin
         r_vsync   <= vsync;
         r_tx      <= w_tx;
         r_ty      <= w_ty;
         r_x       <= w_x;
         r_y       <= w_y;
         r_moving  <= w_tx != w_x || w_ty != w_y;
         // a zero-delta step lands on the target without moving, so it must not pulse
         r_arrived <= w_step && w_at_x && w_at_y && (r_x != r_tx || r_y != r_ty);
         r_state   <= w_step ? (w_at_x && w_at_y ? ST_IDLE : ST_WAIT_FRAME) :
                      r_state == ST_IDLE ? (w_xfer ? ST_WAIT_FRAME : ST_IDLE) :
                      (w_fe ? ST_STEP : ST_WAIT_FRAME);
      end
   end
endmodule

// File: tb/tb_sprite_motion.sv
// tb_sprite_motion: directed stimulus with a per-cycle reference model and literal spot checks
module tb_sprite_motion;
   localparam int STEP = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic vsync = 1'b1;
   logic target_valid = 1'b0;
   logic signed [11:0] target_x = '0;
   logic signed [11:0] target_y = '0;
   logic signed [11:0] x, y;
   logic target_ready, moving, arrived;
   int checks = 0;
   int failures = 0;
   int arr_total = 0;
   int ex, ey, etx, ety, ox, oy, b;
   bit armed, step_now, pv, e_mov, e_arr;
   bit m_ok = 1'b0;

   always #5 clk = ~clk;

   sprite_motion dut (
      .clk(clk), .reset(reset), .vsync(vsync), .target_valid(target_valid),
      .target_x(target_x), .target_y(target_y), .target_ready(target_ready),
      .x(x), .y(y), .moving(moving), .arrived(arrived)
   );

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      return v < lo ? lo : v > hi ? hi : v;
   endfunction

   function automatic int mv(input int p, input int t);
      return (t - p > STEP) ? p + STEP : (t - p < -STEP) ? p - STEP : t;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         ex = 512; ey = 384; etx = 512; ety = 384;
         armed = 0; step_now = 0; pv = 1; e_mov = 0; e_arr = 0; m_ok = 1;
      end else begin
         e_arr = 0;
         if (step_now) begin
            ox = ex; oy = ey;
            ex = mv(ex, etx);
            ey = mv(ey, ety);
            e_arr = ex == etx && ey == ety && (ex != ox || ey != oy);
            armed = !(ex == etx && ey == ety);
            step_now = 0;
         end else begin
            if (pv && !vsync && armed) step_now = 1;
            if (target_valid) begin
               etx = clampi(int'(target_x), 32, 991);
               ety = clampi(int'(target_y), 32, 735);
               armed = 1;
            end
         end
         pv = vsync;
         e_mov = ex != etx || ey != ety;
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("x", int'(x), ex);
         chk("y", int'(y), ey);
         chk("moving", int'(moving), int'(e_mov));
         chk("arrived", int'(arrived), int'(e_arr));
         chk("ready", int'(target_ready), int'(!reset && !step_now));
         if (arrived) arr_total++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic frame();
      vsync = 1'b0;
      repeat (3) tick();
      vsync = 1'b1;
      repeat (7) tick();
   endtask

   task automatic send(input int tx, input int ty);
      bit acc = 1'b0;
      target_x = 12'(tx);
      target_y = 12'(ty);
      target_valid = 1'b1;
      for (int i = 0; i < 20 && !acc; i++) begin
         acc = target_ready;
         tick();
      end
      chk("send_accept", int'(acc), 1);
      target_valid = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_ready", int'(target_ready), 0);
      reset = 1'b0;
      tick();
      chk("t1_ready", int'(target_ready), 1);
      b = arr_total;
      repeat (3) frame();
      chk("t1_x", int'(x), 512);
      chk("t1_y", int'(y), 384);
      chk("t1_moving", int'(moving), 0);
      chk("t1_arrivals", arr_total - b, 0);

      b = arr_total;
      send(520, 380);
      chk("t2_moving", int'(moving), 1);
      frame();
      chk("t2_f1_x", int'(x), 516);
      chk("t2_f1_y", int'(y), 380);
      frame();
      chk("t2_f2_x", int'(x), 520);
      chk("t2_f2_y", int'(y), 380);
      chk("t2_arrivals", arr_total - b, 1);
      chk("t2_moving_end", int'(moving), 0);

      b = arr_total;
      send(2000, -50);
      repeat (120) frame();
      chk("t3_x", int'(x), 991);
      chk("t3_y", int'(y), 32);
      chk("t3_arrivals", arr_total - b, 1);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("t4_init_x", int'(x), 512);
      send(600, 384);
      frame();
      frame();
      chk("t4_mid_x", int'(x), 520);
      send(500, 384);
      frame();
      chk("t4_rev_x", int'(x), 516);
      b = arr_total;
      repeat (5) frame();
      chk("t4_end_x", int'(x), 500);
      chk("t4_arrivals", arr_total - b, 1);

      send(540, 384);
      target_x = 12'sd480;
      target_valid = 1'b1;
      vsync = 1'b0;
      chk("t5_ready_wait", int'(target_ready), 1);
      tick();
      chk("t5_ready_step", int'(target_ready), 0);
      target_x = 12'sd470;
      tick();
      chk("t5_step_x", int'(x), 496);
      chk("t5_ready_after", int'(target_ready), 1);
      tick();
      target_valid = 1'b0;
      vsync = 1'b1;
      repeat (7) tick();
      frame();
      chk("t5_f2_x", int'(x), 492);
      repeat (7) frame();
      chk("t5_end_x", int'(x), 470);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      send(600, 384);
      repeat (7) frame();
      chk("t6_pre_x", int'(x), 540);
      chk("t6_pre_moving", int'(moving), 1);
      b = arr_total;
      reset = 1'b1;
      tick();
      chk("t6_rst_x", int'(x), 512);
      chk("t6_rst_moving", int'(moving), 0);
      chk("t6_rst_arrived", int'(arrived), 0);
      chk("t6_rst_ready", int'(target_ready), 0);
      reset = 1'b0;
      tick();
      repeat (2) frame();
      chk("t6_post_x", int'(x), 512);
      chk("t6_post_moving", int'(moving), 0);
      chk("t6_arrivals", arr_total - b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sprite_motion.md
# sprite_motion

Position animator that sits directly upstream of the triangle sprite renderer and drives its signed 12-bit centre coordinates `x` and `y`. It accepts a target position from the tracking logic over a valid/ready handshake. It then moves the sprite centre toward that target by at most `STEP` pixels per axis per video frame. Updates are committed only at the start of vertical blanking, so the renderer never draws a frame with a half-moved sprite.

## Interface
Parameters:
- `STEP`, 4: maximum per-axis displacement per frame, in pixels; legal range 1..255.
- `X_MIN`, 32: lowest legal centre x.
- `X_MAX`, 991: highest legal centre x.
- `Y_MIN`, 32: lowest legal centre y.
- `Y_MAX`, 735: highest legal centre y.
- `INIT_X`, 512: centre x after reset.
- `INIT_Y`, 384: centre y after reset.

Ports:
- `clk`  in  1  pixel clock (65 MHz); one clock, and `vsync` is in this domain.
- `reset`  in  1  synchronous, active-high reset.
- `vsync`  in  1  active-low vertical sync from the video timing generator.
- `target_valid`  in  1  the value on `target_x`/`target_y` is offered.
- `target_x`  in  12 signed  requested centre x.
- `target_y`  in  12 signed  requested centre y.
- `target_ready`  out  1  the block accepts a target this cycle.
- `x`  out  12 signed  current sprite centre x; feeds the renderer.
- `y`  out  12 signed  current sprite centre y; feeds the renderer.
- `moving`  out  1  the stored target differs from the current position.
- `arrived`  out  1  one-cycle pulse when a frame step lands exactly on the target.

## Operation
- Reset values:
  - `x=INIT_X`, `y=INIT_Y`.
  - Stored target = (`INIT_X`, `INIT_Y`).
  - State IDLE.
  - `target_ready=0`, `moving=0`, `arrived=0`.
  - Internal registered `vsync` = 1.
- Frame edge: asserted when registered `vsync`=1 and current `vsync`=0, i.e. a falling edge. Exactly one frame edge per frame.
- Handshake:
  - A transfer occurs on a cycle where `target_valid && target_ready`.
  - The accepted target is clamped per axis into [MIN, MAX], then stored.
  - A new transfer overwrites any earlier target, including one still in flight.
  - `target_valid` without `target_ready` has no effect; the source must hold its value.
- States:
  - IDLE: `target_ready=1`. A transfer moves the block to WAIT_FRAME. A frame edge with no transfer has no effect.
  - WAIT_FRAME: `target_ready=1`. A frame edge moves the block to STEP. Transfers are accepted and stay in WAIT_FRAME.
  - STEP (one cycle): `target_ready=0`.
    - Per-axis update: `d = target - pos`, computed 13-bit signed. If `|d| <= STEP` then `pos <= target`; otherwise `pos <= pos + sign(d)*STEP`.
    - Next state is IDLE if both axes now equal the target, else WAIT_FRAME.
    - `arrived` pulses on the cycle after STEP if a step made both axes equal the target and the position actually changed. A zero-delta step does not pulse `arrived`.
- `moving` is a combinational compare of stored target and position, registered. It is 1 from the cycle after a transfer that differs from the position, and drops in the same cycle as `arrived`.
- Arithmetic: clamped targets and positions are always in bounds, so `pos ± STEP` toward the target can never overshoot the target or leave bounds. No saturation is needed on the step result.
- Simultaneous events:
  - A transfer and a frame edge in the same cycle in WAIT_FRAME: the new target is stored, and the STEP in the next cycle uses it.
  - A transfer and a frame edge in the same cycle in IDLE: the block goes to WAIT_FRAME and waits for the next frame.
- Reset mid-motion: the position returns to INIT immediately on the next edge. The pending target is discarded.

## Timing
- Frame edge detected at cycle N; state is STEP in N+1; `x`/`y` hold new values from N+2.
- `arrived` is high for cycle N+2 only.
- Worst-case frames to arrive = ceil(max(|dx|,|dy|)/STEP).
- `x`, `y` are registered outputs; there is no combinational path from any input to them.
- `target_ready` is low for exactly one cycle per frame while moving, and always low during reset.

## Structure
- Shared package, shared with the renderer and tracking logic:
  - `COORD_W=12`.
  - Screen size 1024×768.
  - Default bounds and default sprite half-size.
  - State encoding (IDLE, WAIT_FRAME, STEP).
- One sub-module, `axis_stepper`, instantiated once for x and once for y.
  - Combinational: `pos`, `target`, `STEP` in; `next_pos`, `at_target` out.
  - Owns the 13-bit delta math.

## Test plan
- Reset, then 3 frames with no transfer -> `x=512`, `y=384`, `moving=0`, no `arrived`, `target_ready=1` after reset.
- Transfer (520, 380), STEP=4 -> after frame 1 `x=516`, `y=380`; after frame 2 `x=520`, `y=380`; `arrived` pulses once at N+2 of frame 2.
- Transfer (2000, -50) -> stored target clamps to (991, 32); after 120 frames `x=991`, `y=32`; `arrived` pulses exactly once.
- Mid-motion, 2 frames toward (600, 384), then transfer (500, 384) -> `x` reverses to 516 on the next frame, then continues down to 500.
- Transfer asserted in the same cycle as a frame edge while in WAIT_FRAME -> the following STEP uses the new target; `target_ready=0` in the STEP cycle, so a transfer offered then is held and taken the cycle after.
- `reset` asserted while `x=540` and moving -> the next cycle shows `x=512`, IDLE, `moving=0`, and no `arrived` pulse.
